// File: rtl/arb_pkg.sv
// Shared types and constants for the fetch/LSU memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int unsigned MAX_RD_LAT = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = 4;

endpackage

// File: rtl/rsp_tag_pipe.sv
// Owner-tag shift register that tracks which requester each in-flight read
// belongs to, with flush kill of fetch tags and tail decode.
module rsp_tag_pipe
  import arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  owner_t push_tag,
  output logic   if_hit_c,
  output logic   d_hit_c
);

  localparam int unsigned DEPTH = (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT;

  owner_t tags [DEPTH];

  // Flush turns every fetch tag it touches (new or in flight) into a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tags[i] <= OWN_NONE;
      end
    end else begin
      tags[0] <= (flush && push_tag == OWN_IF) ? OWN_NONE : push_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        tags[i] <= (flush && tags[i-1] == OWN_IF) ? OWN_NONE : tags[i-1];
      end
    end
  end

  // A fetch response landing in the flush cycle belongs to dead instructions.
  always_comb begin
    if_hit_c = (tags[DEPTH-1] == OWN_IF) && !flush;
    d_hit_c  = (tags[DEPTH-1] == OWN_D);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/LSU arbiter for a single-port fixed-latency memory: data priority,
// bounded fetch starvation, in-order response routing and flush kill.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic [BE_W-1:0]   i_d_be,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [BE_W-1:0]   o_mem_be,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             if_gnt_c;
  logic             d_gnt_c;
  logic             if_hit_c;
  logic             d_hit_c;
  owner_t           push_tag;

  // Data wins contention until fetch has been passed over STARVE_MAX times.
  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (i_rst_n) begin
      if (i_if_req && i_d_req) begin
        if (starve_cnt == CNT_W'(STARVE_MAX)) begin
          if_gnt_c = 1'b1;
        end else begin
          d_gnt_c = 1'b1;
        end
      end else begin
        if_gnt_c = i_if_req;
        d_gnt_c  = i_d_req;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (if_gnt_c || !i_if_req) begin
      starve_cnt <= '0;
    end else if (d_gnt_c && starve_cnt != CNT_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    if (if_gnt_c) begin
      o_mem_addr = i_if_addr;
      o_mem_be   = '1;
    end else if (d_gnt_c) begin
      o_mem_we    = i_d_we;
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
      o_mem_be    = i_d_be;
    end
  end

  always_comb begin
    push_tag = OWN_NONE;
    if (if_gnt_c) begin
      push_tag = OWN_IF;
    end else if (d_gnt_c && !i_d_we) begin
      push_tag = OWN_D;
    end
  end

  rsp_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .flush    (i_flush),
    .push_tag (push_tag),
    .if_hit_c (if_hit_c),
    .d_hit_c  (d_hit_c)
  );

  assign o_if_gnt    = if_gnt_c;
  assign o_d_gnt     = d_gnt_c;
  assign o_mem_req   = if_gnt_c | d_gnt_c;
  assign o_if_rvalid = if_hit_c;
  assign o_d_rvalid  = d_hit_c;
  assign o_if_rdata  = if_hit_c ? i_mem_rdata : '0;
  assign o_d_rdata   = d_hit_c ? i_mem_rdata : '0;

endmodule
